cp0_ext: RTL and testbench
==========================

# cp0_ext

Parametrised coprocessor-0 for the pipelined MIPS core. It holds the SR, Cause, EPC, BadVAddr, Count, Compare and PRId registers and arbitrates hardware, software and timer interrupts against internal exceptions. It asserts `go_handle` combinationally to redirect the pipeline. It sits beside the M-stage, which supplies the faulting PC, the exception code and the delay-slot flag.

## Interface
- `NHW`, 6: number of connected hardware interrupt lines (1..6); line i maps to Cause.IP[2+i].
- `TIMER_EN`, 1: 1 enables the Count/Compare timer; the timer interrupt is ORed into IP[7].
- `PRESCALE`, 1: number of clk cycles per Count increment (≥1).
- `PRID`, 32'h0000_0100: read-only value of register 15.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `rd_addr` in 5: mfc0 register index.
- `rd_data` out 32: combinational read data.
- `wr_en` in 1: mtc0 write strobe.
- `wr_addr` in 5: mtc0 register index.
- `wr_data` in 32: mtc0 data.
- `eret` in 1: eret retiring; clears EXL.
- `in_delay_slot` in 1: the M-stage instruction is in a branch delay slot.
- `hw_int` in NHW: level-sensitive external interrupt lines.
- `exc_code` in 5: internal exception code; 0 means no exception.
- `exc_badvaddr` in 32: faulting address for AdEL (4) and AdES (5).
- `pc_now` in 32: PC of the M-stage instruction.
- `epc` out 32: current EPC register value.
- `go_handle` out 1: take the exception or interrupt this cycle.

## Operation
- **Register map.**
  - 8 BadVAddr (read-only).
  - 9 Count.
  - 11 Compare.
  - 12 SR = {16'b0, IM[7:0], 6'b0, EXL, IE}.
  - 13 Cause = {BD, TI, 14'b0, IP[7:0], 1'b0, ExcCode[4:0], 2'b0}.
  - 14 EPC.
  - 15 PRId.
  - Any other index reads 0; writes to it are ignored.
- **IP bits.**
  - IP[1:0] are software interrupt bits, writable via Cause.
  - IP[2+i] follows `hw_int[i]` live every cycle; IP bits for unconnected lines read 0.
  - IP[7] = (hw line 5 if NHW=6) | (TI & TIMER_EN).
- **Request logic.**
  - int_req = |(IP & IM) & IE & ~EXL.
  - exc_req = (exc_code≠0) & ~EXL.
  - go_handle = int_req | exc_req.
- **Priority.** If int_req and exc_req are both true, the interrupt wins and ExcCode=0. EPC points at the faulting instruction, which re-executes and re-raises its exception after eret.
- **On go_handle, at the next edge:**
  - EXL←1.
  - BD←`in_delay_slot`.
  - EPC←`pc_now`−4 if `in_delay_slot`, else `pc_now` (32-bit wrap).
  - ExcCode←0 on an interrupt, else `exc_code`.
  - BadVAddr←`exc_badvaddr` only for a non-interrupt take with exc_code 4 or 5.
  - mtc0 writes in the same cycle are dropped.
- **mtc0 writes, when go_handle=0:**
  - SR loads IM, EXL, IE.
  - Cause loads only IP[1:0]; BD, TI and ExcCode are read-only to software.
  - EPC loads the full word.
  - Count loads the value and clears the prescaler.
  - Compare loads the value and clears TI.
- **eret.** Clears EXL at the next edge. An mtc0 SR write in the same cycle takes precedence.
- **Timer (TIMER_EN=1).**
  - A prescaler counts 0..PRESCALE−1; a tick occurs when it equals PRESCALE−1.
  - On a tick, Count←Count+1 (mod 2^32); if Count before the increment equals Compare, TI←1.
  - TI stays set until Compare is written.
  - A Count write in a tick cycle wins; no increment and no TI set that cycle.
  - A Compare write and a TI set in the same cycle: the write wins, so TI=0.
  - The timer runs regardless of EXL.
- **Timer (TIMER_EN=0).** Count and Compare read 0 and TI is held at 0.

## Timing
- **Reset values.**
  - SR, Cause, EPC, BadVAddr and Count = 0; Compare = 32'hFFFF_FFFF; prescaler = 0; TI = 0.
  - `rd_data` shows the register addressed by `rd_addr`; `epc` = 0.
  - `go_handle` = 0, except for a nonzero `exc_code`, which still raises it because EXL=0.
- **Latency.**
  - `rd_data` and `go_handle` are combinational, with zero latency, from the current state and inputs.
  - All register updates are visible one edge later.
  - There is no read-after-write bypass: an mfc0 in the same cycle as an mtc0 to the same register returns the old value.
- **Reset mid-operation.** Asserting `rst` asynchronously forces all state to its reset value, including an in-flight EXL and a pending TI.
- **Nesting.** While EXL=1, no new take is possible; pending requests are held off until eret clears EXL and are taken in the following cycle if still asserted.

## Test plan
- **Delay-slot exception.** Reset; SR←0x0000_FC01; exc_code=12 at pc_now=0x3008 with in_delay_slot=1 → go_handle=1 that cycle; next cycle EPC=0x3004, BD=1, ExcCode=12, EXL=1, and go_handle=0 even though exc_code is still 12.
- **Interrupt beats exception.** IM=0x04, IE=1; hw_int[0]=1 together with exc_code=4 and exc_badvaddr=0x1001 → ExcCode=0, EPC=pc_now, BadVAddr unchanged; a repeat with IE=0 → ExcCode=4, BadVAddr=0x1001.
- **Timer.** PRESCALE=2; Compare←5; Count←0 → TI sets after the tick at which Count goes 5→6 (12 cycles after the writes); with IM[7]=1 and IE=1, go_handle=1 the same cycle; Compare←100 → TI=0 on the next cycle.
- **Software interrupt and dropped write.** Cause←0x0000_0100 with IM[0]=1, IE=1 → go_handle=1 next cycle; an mtc0 EPC←0xDEAD in that take cycle is dropped, so EPC=pc_now.
- **eret.** Take an interrupt, then assert eret → EXL=0 next cycle; a still-asserted hw_int is re-taken the cycle after that.
- **Async reset.** Assert rst mid-handler between clock edges → EXL, TI and EPC clear immediately; Compare reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/cp0_ext.sv
// Coprocessor 0 for the pipelined MIPS core: status/cause/EPC/timer registers
// and the combinational take decision that redirects the pipeline.
module cp0_ext #(
    parameter int          NHW      = 6,
    parameter bit          TIMER_EN = 1'b1,
    parameter int          PRESCALE = 1,
    parameter logic [31:0] PRID     = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rd_addr,
    output logic [31:0]     rd_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [31:0]     wr_data,
    input  logic            eret,
    input  logic            in_delay_slot,
    input  logic [NHW-1:0]  hw_int,
    input  logic [4:0]      exc_code,
    input  logic [31:0]     exc_badvaddr,
    input  logic [31:0]     pc_now,
    output logic [31:0]     epc,
    output logic            go_handle
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [7:0]    im;
    logic          exl, ie, bd, ti;
    logic [1:0]    ip_sw;
    logic [4:0]    exc_code_r;
    logic [31:0]   epc_r, badvaddr_r, count_r, compare_r;
    logic [PW-1:0] presc;

    logic [5:0]    hw_pad;
    logic [7:0]    ip;
    logic          int_req, exc_req, tick;
    logic          wr_sr, wr_cause, wr_epc, wr_count, wr_compare;

    // Unconnected hardware lines read as zero.
    always_comb begin
        hw_pad = '0;
        for (int i = 0; i < NHW; i++) hw_pad[i] = hw_int[i];
    end

    assign ip = {hw_pad[5] | (ti & TIMER_EN), hw_pad[4:0], ip_sw};

    assign int_req   = (|(ip & im)) & ie & ~exl;
    assign exc_req   = (exc_code != 5'd0) & ~exl;
    assign go_handle = int_req | exc_req;
    assign epc       = epc_r;

    // mtc0 is dropped in a take cycle.
    assign wr_sr      = wr_en & ~go_handle & (wr_addr == 5'd12);
    assign wr_cause   = wr_en & ~go_handle & (wr_addr == 5'd13);
    assign wr_epc     = wr_en & ~go_handle & (wr_addr == 5'd14);
    assign wr_count   = wr_en & ~go_handle & (wr_addr == 5'd9);
    assign wr_compare = wr_en & ~go_handle & (wr_addr == 5'd11);

    assign tick = (presc == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            ip_sw      <= '0;
            exc_code_r <= '0;
            epc_r      <= '0;
            badvaddr_r <= '0;
        end else if (go_handle) begin
            exl        <= 1'b1;
            bd         <= in_delay_slot;
            epc_r      <= in_delay_slot ? pc_now - 32'd4 : pc_now;
            exc_code_r <= int_req ? 5'd0 : exc_code;
            if (!int_req && (exc_code == 5'd4 || exc_code == 5'd5))
                badvaddr_r <= exc_badvaddr;
        end else begin
            if (wr_sr) begin
                im  <= wr_data[15:8];
                exl <= wr_data[1];
                ie  <= wr_data[0];
            end else if (eret) begin
                exl <= 1'b0;
            end
            if (wr_cause) ip_sw <= wr_data[9:8];
            if (wr_epc)   epc_r <= wr_data;
        end
    end

    // Timer keeps running while EXL is set; software writes beat the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r   <= '0;
            compare_r <= 32'hFFFF_FFFF;
            presc     <= '0;
            ti        <= 1'b0;
        end else if (TIMER_EN) begin
            if (wr_count) begin
                count_r <= wr_data;
                presc   <= '0;
            end else if (tick) begin
                count_r <= count_r + 32'd1;
                presc   <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
            if (wr_compare) begin
                compare_r <= wr_data;
                ti        <= 1'b0;
            end else if (tick && !wr_count && count_r == compare_r) begin
                ti <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            5'd8:  rd_data = badvaddr_r;
            5'd9:  rd_data = TIMER_EN ? count_r : 32'd0;
            5'd11: rd_data = TIMER_EN ? compare_r : 32'd0;
            5'd12: rd_data = {16'b0, im, 6'b0, exl, ie};
            5'd13: rd_data = {bd, ti, 14'b0, ip, 1'b0, exc_code_r, 2'b0};
            5'd14: rd_data = epc_r;
            5'd15: rd_data = PRID;
            default: rd_data = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_ext.sv
// Directed bench for cp0_ext: exceptions, interrupts, timer, eret, async reset.
`timescale 1ns/1ps
module tb_cp0_ext;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        eret;
    logic        in_delay_slot;
    logic [5:0]  hw_int;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic [31:0] pc_now;
    logic [31:0] epc;
    logic        go_handle;

    int n_chk  = 0;
    int n_fail = 0;

    cp0_ext #(.NHW(6), .TIMER_EN(1'b1), .PRESCALE(2), .PRID(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .eret(eret),
        .in_delay_slot(in_delay_slot), .hw_int(hw_int), .exc_code(exc_code),
        .exc_badvaddr(exc_badvaddr), .pc_now(pc_now), .epc(epc), .go_handle(go_handle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        eret = 1'b0; in_delay_slot = 1'b0; hw_int = '0; exc_code = '0;
        exc_badvaddr = '0; pc_now = '0;
        #2;
        chk("rst_go", {31'b0, go_handle}, 32'd0);
        chk("rst_epc", epc, 32'd0);
        rd(5'd12, 32'd0, "rst_sr");
        rd(5'd13, 32'd0, "rst_cause");
        rd(5'd11, 32'hFFFF_FFFF, "rst_compare");
        rd(5'd15, 32'h0000_0100, "prid");
        exc_code = 5'd12; #1;
        chk("rst_exc_go", {31'b0, go_handle}, 32'd1);
        exc_code = 5'd0;
        @(negedge clk); rst = 1'b0;
        step();

        // SR write, no read-after-write bypass
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_FC01;
        rd(5'd12, 32'd0, "sr_no_bypass");
        step(); wr_en = 1'b0;
        rd(5'd12, 32'h0000_FC01, "sr_write");
        wr(5'd3, 32'h1234_5678);
        rd(5'd3, 32'd0, "unmapped");

        // Delay-slot exception
        exc_code = 5'd12; pc_now = 32'h3008; in_delay_slot = 1'b1; #1;
        chk("ds_go", {31'b0, go_handle}, 32'd1);
        step();
        chk("ds_epc", epc, 32'h3004);
        rd(5'd13, 32'h8000_0030, "ds_cause");
        rd(5'd12, 32'h0000_FC03, "ds_sr");
        chk("ds_go_held", {31'b0, go_handle}, 32'd0);
        exc_code = 5'd0; in_delay_slot = 1'b0; eret = 1'b1;
        step(); eret = 1'b0;
        rd(5'd12, 32'h0000_FC01, "eret_sr");

        // Interrupt beats exception
        wr(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; exc_code = 5'd4; exc_badvaddr = 32'h1001; pc_now = 32'h4000; #1;
        chk("ie_go", {31'b0, go_handle}, 32'd1);
        step();
        rd(5'd13, 32'h0000_0400, "ie_cause");
        chk("ie_epc", epc, 32'h4000);
        rd(5'd8, 32'd0, "ie_badv");
        hw_int = '0; exc_code = '0;
        wr(5'd12, 32'h0000_0400);
        hw_int = 6'b000001; exc_code = 5'd4; pc_now = 32'h4100; #1;
        chk("ex_go", {31'b0, go_handle}, 32'd1);
        step();
        rd(5'd13, 32'h0000_0410, "ex_cause");
        rd(5'd8, 32'h0000_1001, "ex_badv");
        chk("ex_epc", epc, 32'h4100);
        hw_int = '0; exc_code = '0;
        wr(5'd12, 32'h0000_0000);

        // Software interrupt with dropped mtc0
        wr(5'd12, 32'h0000_0101);
        wr(5'd13, 32'h0000_0100);
        chk("sw_go", {31'b0, go_handle}, 32'd1);
        pc_now = 32'h5000;
        wr(5'd14, 32'h0000_DEAD);
        chk("sw_epc", epc, 32'h5000);
        rd(5'd13, 32'h0000_0100, "sw_cause");
        wr(5'd13, 32'h0);
        wr(5'd12, 32'h0);

        // eret and re-take
        wr(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; pc_now = 32'h6000; #1;
        chk("er_go", {31'b0, go_handle}, 32'd1);
        step();
        chk("er_go_off", {31'b0, go_handle}, 32'd0);
        rd(5'd12, 32'h0000_0403, "er_sr_exl");
        eret = 1'b1; step(); eret = 1'b0;
        rd(5'd12, 32'h0000_0401, "er_sr_clr");
        chk("er_retake", {31'b0, go_handle}, 32'd1);
        step();
        rd(5'd12, 32'h0000_0403, "er_sr_again");
        hw_int = '0;

        // Timer, PRESCALE=2
        wr(5'd12, 32'h0000_8001);
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        rd(5'd9, 32'd0, "tm_count0");
        repeat (11) step();
        rd(5'd9, 32'd5, "tm_count5");
        chk("tm_go_pre", {31'b0, go_handle}, 32'd0);
        step();
        chk("tm_go", {31'b0, go_handle}, 32'd1);
        rd(5'd13, 32'h4000_8000, "tm_cause_ti");
        rd(5'd9, 32'd6, "tm_count6");
        step();
        wr(5'd11, 32'd100);
        rd(5'd13, 32'h0000_0000, "tm_ti_clr");

        // Pending TI under EXL, then async reset
        wr(5'd11, 32'd0);
        wr(5'd9, 32'd0);
        step(); step();
        rd(5'd13, 32'h4000_8000, "ar_ti_pend");
        rd(5'd12, 32'h0000_8003, "ar_exl_pend");
        #1; rst = 1'b1; #1;
        rd(5'd12, 32'd0, "ar_sr");
        rd(5'd13, 32'd0, "ar_cause");
        rd(5'd11, 32'hFFFF_FFFF, "ar_compare");
        chk("ar_epc", epc, 32'd0);
        @(negedge clk); rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
